// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller.
// Accepts one pipeline access at a time, checks alignment and range, drives
// the data-memory strobes for WAIT_CYCLES cycles and reports completion with a
// one-cycle ack pulse. Misaligned or out-of-range requests complete at once
// with err=1 and never touch the memory.
module lsu_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MEM_WORDS   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_memread,
    output logic        mem_memwrite,
    inout  wire  [31:0] mem_writedata,
    input  logic [31:0] mem_readdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    // Counter value seen on the final ACCESS edge.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        we_q, we_n;
    logic [31:0] wdata_q, wdata_n;

    logic        busy_n, ack_n, err_n;
    logic        memread_n, memwrite_n;
    logic [31:0] rdata_n, mem_address_n;
    logic        req_bad;

    // A request is illegal if it is not word aligned or falls past the last word.
    assign req_bad = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    // The write bus is driven only while a store holds the write strobe.
    assign mem_writedata = mem_memwrite ? wdata_q : {32{1'bz}};

    // Next-state and next-output logic for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n       = state;
        cnt_n         = cnt;
        we_n          = we_q;
        wdata_n       = wdata_q;
        ack_n         = ack;
        err_n         = err;
        rdata_n       = rdata;
        mem_address_n = mem_address;
        memread_n     = mem_memread;
        memwrite_n    = mem_memwrite;

        case (state)
            IDLE: begin
                if (req) begin
                    we_n    = req_we;
                    wdata_n = req_wdata;
                    if (req_bad) begin
                        state_n = DONE;
                        ack_n   = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        state_n       = ACCESS;
                        cnt_n         = 4'd0;
                        mem_address_n = {2'b00, req_addr[31:2]};
                        memread_n     = ~req_we;
                        memwrite_n    = req_we;
                    end
                end
            end
            ACCESS: begin
                if (cnt == LAST_CNT) begin
                    state_n    = DONE;
                    memread_n  = 1'b0;
                    memwrite_n = 1'b0;
                    ack_n      = 1'b1;
                    err_n      = 1'b0;
                    if (!we_q) begin
                        rdata_n = mem_readdata;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                ack_n   = 1'b0;
                err_n   = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, counter, latched request and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            busy         <= 1'b0;
            ack          <= 1'b0;
            err          <= 1'b0;
            rdata        <= 32'd0;
            mem_address  <= 32'd0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            we_q         <= we_n;
            wdata_q      <= wdata_n;
            busy         <= busy_n;
            ack          <= ack_n;
            err          <= err_n;
            rdata        <= rdata_n;
            mem_address  <= mem_address_n;
            mem_memread  <= memread_n;
            mem_memwrite <= memwrite_n;
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2: number of cycles the memory strobes are held per access (legal range 1..15).
REQ-002 The block SHALL have parameter MEM_WORDS, default 64: number of 32-bit words in the attached data memory.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; both are sampled on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  1  access request from the pipeline, sampled only in IDLE.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  error flag, valid only while ack=1.
REQ-013 rdata  output  32  last completed load data.
REQ-014 mem_address  output  32  word index to the data memory.
REQ-015 mem_memread  output  1  read strobe.
REQ-016 mem_memwrite  output  1  write strobe.
REQ-017 mem_writedata  inout  32  bidirectional data bus to the memory; the block drives it only during a store ACCESS and leaves it at high-Z (32'hzzzzzzzz) otherwise.
REQ-018 mem_readdata  input  32  read data returned by the memory.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, ACCESS and DONE, with all outputs registered.
REQ-020 In IDLE, req=1 SHALL latch req_we, req_addr and req_wdata on that edge; a request is never dropped or queued.
REQ-021 A request SHALL be flagged as an error when req_addr[1:0]!=0 or req_addr[31:2]>=MEM_WORDS.
REQ-022 An error request SHALL go IDLE->DONE with no strobe asserted, so that ack=1 and err=1 appear in cycle 1 after acceptance.
REQ-023 A legal request SHALL go IDLE->ACCESS with mem_address=req_addr>>2 and exactly one strobe asserted: mem_memread=~req_we or mem_memwrite=req_we.
REQ-024 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter cleared on entry.
REQ-025 For a load, rdata SHALL capture mem_readdata on the last ACCESS edge.
REQ-026 ACCESS->DONE SHALL deassert both strobes, release mem_writedata to high-Z and assert ack=1 with err=0.
REQ-027 Legal access latency SHALL be: accept at edge 0, ACCESS during cycles 1..WAIT_CYCLES, ack in cycle WAIT_CYCLES+1.
REQ-028 DONE SHALL last one cycle and then return to IDLE; ack and err SHALL clear on that edge.
REQ-029 A new request can be accepted no earlier than the cycle after DONE (back-to-back period WAIT_CYCLES+2).
REQ-030 req SHALL be ignored while busy=1.
REQ-031 rdata SHALL hold its value through stores and error requests, changing only on load completion.
REQ-032 mem_address SHALL hold its last value when not in ACCESS.

Reset
REQ-033 On reset=1 the block SHALL enter IDLE and clear the counter.
REQ-034 On reset=1 the outputs SHALL take: busy=0, ack=0, err=0, rdata=0, mem_address=0, mem_memread=0, mem_memwrite=0, mem_writedata=high-Z.
REQ-035 Reset asserted mid-ACCESS SHALL abort the access at that edge, with the strobes low next cycle and no ack generated.
REQ-036 Reset SHALL take priority over a simultaneous req.

Verification
REQ-037 Store: WAIT_CYCLES=2, req_we=1, req_addr=0x8, req_wdata=0xDEADBEEF -> mem_address=2, mem_memwrite=1 and mem_writedata=0xDEADBEEF for 2 cycles; ack in cycle 3; bus at Z afterwards.
REQ-038 Load: req_we=0, req_addr=0x8 with the memory returning 0xDEADBEEF -> mem_memread=1 for 2 cycles; rdata=0xDEADBEEF with ack=1, err=0 in cycle 3.
REQ-039 Misaligned: req_addr=0x6 -> no strobe; ack=1, err=1 in cycle 1; rdata unchanged.
REQ-040 Out of range: req_addr=0x100 with MEM_WORDS=64 -> ack=1, err=1 in cycle 1; strobes never high.
REQ-041 Busy: req held high continuously for two loads (0x0, 0x4) -> second accepted in the cycle after DONE; acks 4 cycles apart; no extra strobe.
REQ-042 Reset mid-access: reset in cycle 1 of a store -> strobes low, busy=0, bus Z next cycle; no ack.
